tdc_evt_sched: RTL and testbench
================================

Name: tdc_evt_sched

Overview:
- Round-robin scheduler sharing one timestamp FIFO between NCHAN TDC capture channels inside opentdc_wb.
- Each channel presents a captured timestamp with a valid/ack handshake. The scheduler grants at most one channel per cycle and pushes {channel index, timestamp} into an internal FIFO.
- The Wishbone register logic pops the FIFO for software readout.
- Also reports FIFO level and a sticky overflow/stall flag.

Parameters:
- NCHAN, 4: number of requesting TDC channels (2..8).
- TS_W, 16: timestamp width per channel.
- DEPTH, 8: FIFO entries; must be a power of 2, at least 2.
- (derived) CW = max(1, clog2(NCHAN)): channel-index width. AW = clog2(DEPTH).

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  synchronous, active-high reset.
- en_mask_i  in  NCHAN  per-channel enable; a disabled channel is never granted.
- ch_valid_i  in  NCHAN  channel has a timestamp pending; held until acked.
- ch_ts_i  in  NCHAN*TS_W  timestamps; channel k occupies bits [k*TS_W +: TS_W].
- ch_ack_o  out  NCHAN  one-hot grant/consume pulse, combinational from current state.
- rd_i  in  1  pop request from the register interface.
- rd_valid_o  out  1  FIFO not empty.
- rd_data_o  out  CW+TS_W  head entry {chan, ts}; valid only when rd_valid_o=1.
- level_o  out  AW+1  current occupancy, 0..DEPTH.
- ovf_o  out  1  sticky: a request was stalled (or dropped) because the FIFO was full.
- ovf_clr_i  in  1  clears ovf_o.

Behaviour:
- Reset (wb_rst_i=1 at a clock edge):
  - rd/wr pointers and level_o are 0; rd_valid_o=0.
  - ovf_o=0; round-robin pointer rr=0.
  - ch_ack_o=0 during the reset cycle.
  - FIFO contents are not cleared.
  - Reset mid-operation discards all queued entries. Pending channel requests stay asserted and are served after reset.
- Eligible set: E = ch_valid_i & en_mask_i.
- Grant:
  - Winner is the first k in E, searching upward from rr and wrapping NCHAN-1 -> 0.
  - If E≠0 and level_o<DEPTH: ch_ack_o[winner]=1 this cycle, the entry is written at the clock edge, and rr <= winner+1 (mod NCHAN).
  - If E=0: no ack and rr is unchanged.
- Full (level_o==DEPTH) with E≠0:
  - No ack; rr is unchanged; ovf_o <= 1.
  - Full is judged on the registered level; a same-cycle pop does not enable a push. This keeps the path free of combinational rd_i -> ack.
- Pop:
  - When rd_i=1 and rd_valid_o=1, the read pointer advances at the edge. rd_data_o shows the next head in the following cycle (show-ahead; data is valid combinationally from the head).
  - rd_i while empty is ignored.
- Level update:
  - Simultaneous push and pop: level is unchanged; both pointers advance.
  - Push only: level +1. Pop only: level -1.
  - Pointers wrap modulo DEPTH.
- Latency: a granted timestamp is visible on rd_data_o one cycle after the ack when the FIFO was empty.
- ovf_clr_i: ovf_o <= 0 unless a set condition occurs in the same cycle (set wins).
- Disabled channels: a valid request is ignored, and its ack stays 0 indefinitely.
- A channel is re-served only after every other eligible channel has had a grant (fairness bound: NCHAN-1 intervening grants).

Optional Feature:
- Macro: TDC_SCHED_DROP_EN.
- Defined:
  - When full with E≠0, the winner is still acked and rr advances, but the entry is discarded.
  - ovf_o is set.
  - An 8-bit saturating counter drop_cnt increments on each such drop; it is exposed on the extra output port drop_cnt_o[7:0] and cleared by ovf_clr_i.
  - Channels never stall.
- Not defined:
  - Full stalls the requester as described above.
  - No drop_cnt_o port exists.

Test Plan:
- Reset, then ch_valid_i=4'b0001, ts0=16'h1234 -> ack0 pulses 1 cycle; next cycle rd_valid_o=1, rd_data_o={2'd0,16'h1234}, level_o=1.
- All 4 channels valid and enabled continuously, rd_i=0 -> acks in order ch0,ch1,ch2,ch3,ch0,…; level_o reaches 8 after 8 cycles, then acks stop and ovf_o=1.
- Full FIFO with rd_i=1 for one cycle and a request pending -> level_o 8->7 with no ack that cycle; next cycle ack is granted and level_o returns to 8.
- en_mask_i=4'b1011, all valid -> ch2 is never acked; order is 0,1,3,0,1,3.
- Push and pop in the same cycle at level_o=3 -> level_o stays 3; FIFO order is preserved when read back. Assert ovf_clr_i while a full stall is active -> ovf_o stays 1.
- TDC_SCHED_DROP_EN defined: fill to 8, keep ch1 valid for 300 cycles -> ch1 acked every cycle, level_o=8, drop_cnt_o saturates at 255, ovf_o=1.

Source files
------------

// File: rtl/tdc_evt_sched.sv
// tdc_evt_sched: round-robin TDC channel scheduler feeding a shared show-ahead timestamp FIFO.
// Optional macro TDC_SCHED_DROP_EN: when full, grant and discard instead of stalling, and count drops.
module tdc_evt_sched #(
   parameter int NCHAN = 4,
   parameter int TS_W = 16,
   parameter int DEPTH = 8,
   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [NCHAN-1:0]      en_mask_i,
   input  logic [NCHAN-1:0]      ch_valid_i,
   input  logic [NCHAN*TS_W-1:0] ch_ts_i,
   output logic [NCHAN-1:0]      ch_ack_o,
   input  logic                  rd_i,
   output logic                  rd_valid_o,
   output logic [CW+TS_W-1:0]    rd_data_o,
   output logic [AW:0]           level_o,
   output logic                  ovf_o,
`ifdef TDC_SCHED_DROP_EN
   output logic [7:0]            drop_cnt_o,
`endif
   input  logic                  ovf_clr_i
);
   logic [CW+TS_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] level;
   logic [CW-1:0] rr, win, win_hi, win_lo;
   logic [NCHAN-1:0] e;
   logic hit_hi, any, full, grant, push, pop, stall;
   assign e = ch_valid_i & en_mask_i;
   assign any = |e;
   assign full = level == (AW+1)'(DEPTH);
   // lowest eligible at/above rr wins; otherwise wrap to lowest eligible overall
   always_comb begin
      win_hi = '0;
      win_lo = '0;
      hit_hi = 1'b0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (e[i] && i >= int'(rr)) begin
            win_hi = CW'(i);
            hit_hi = 1'b1;
         end
         if (e[i]) win_lo = CW'(i);
      end
   end
   assign win = hit_hi ? win_hi : win_lo;
`ifdef TDC_SCHED_DROP_EN
   assign grant = any & ~wb_rst_i;
`else
   assign grant = any & ~full & ~wb_rst_i;
`endif
   assign push = grant & ~full;
   assign stall = any & full;
   assign pop = rd_i & rd_valid_o;
   assign ch_ack_o = grant ? NCHAN'(1) << win : '0;
   assign rd_valid_o = level != '0;
   assign rd_data_o = mem[rd_ptr];
   assign level_o = level;
   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr] <= {win, ch_ts_i[win*TS_W +: TS_W]};
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         rr <= '0;
         ovf_o <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         level <= (push == pop) ? level : push ? level + 1'b1 : level - 1'b1;
         if (grant) rr <= (win == CW'(NCHAN - 1)) ? '0 : win + 1'b1;
         ovf_o <= stall | (ovf_o & ~ovf_clr_i);
      end
   end
`ifdef TDC_SCHED_DROP_EN
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) drop_cnt_o <= '0;
      else if (stall) drop_cnt_o <= drop_cnt_o + {7'd0, drop_cnt_o != 8'hFF};
      else if (ovf_clr_i) drop_cnt_o <= '0;
   end
`endif
endmodule

// File: tb/tb_tdc_evt_sched.sv
// tb_tdc_evt_sched: directed and random stimulus checked against a queue-based scheduler model.
module tb_tdc_evt_sched;
   localparam int NCHAN = 4;
   localparam int TS_W = 16;
   localparam int DEPTH = 8;
   localparam int CW = 2;
   localparam int AW = 3;
`ifdef TDC_SCHED_DROP_EN
   localparam bit DROP = 1'b1;
   logic [7:0] drop_cnt_o;
`else
   localparam bit DROP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_r = 1'b1;
   logic [NCHAN-1:0] mask_r = '0;
   logic [NCHAN-1:0] valid_r = '0;
   logic [NCHAN*TS_W-1:0] ts_r = '0;
   logic [NCHAN-1:0] ch_ack_o;
   logic rd_r = 1'b0;
   logic rd_valid_o;
   logic [CW+TS_W-1:0] rd_data_o;
   logic [AW:0] level_o;
   logic ovf_o;
   logic clr_r = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [CW+TS_W-1:0] q[$];
   logic [NCHAN-1:0] pend = '0;
   int rr_m = 0;
   bit ovf_m = 1'b0;
   int drop_m = 0;
   always #5 clk = ~clk;
   tdc_evt_sched dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst_r),
      .en_mask_i(mask_r),
      .ch_valid_i(valid_r),
      .ch_ts_i(ts_r),
      .ch_ack_o(ch_ack_o),
      .rd_i(rd_r),
      .rd_valid_o(rd_valid_o),
      .rd_data_o(rd_data_o),
      .level_o(level_o),
      .ovf_o(ovf_o),
`ifdef TDC_SCHED_DROP_EN
      .drop_cnt_o(drop_cnt_o),
`endif
      .ovf_clr_i(clr_r)
   );
   // One clock: drive inputs after the edge, check outputs mid-cycle, then advance the model to the next edge.
   task automatic step(input logic rst, input logic [NCHAN-1:0] req, input logic [NCHAN-1:0] mask,
                       input logic rd, input logic clr);
      logic [NCHAN-1:0] el, exp_ack;
      int win;
      bit do_pop, do_push, stalled;
      @(posedge clk);
      #1;
      pend = pend | req;
      rst_r = rst;
      valid_r = pend;
      mask_r = mask;
      rd_r = rd;
      clr_r = clr;
      for (int k = 0; k < NCHAN; k++) ts_r[k*TS_W +: TS_W] = TS_W'($urandom);
      #3;
      el = pend & mask;
      win = -1;
      for (int d = 0; d < NCHAN; d++)
         if (win < 0 && el[(rr_m + d) % NCHAN]) win = (rr_m + d) % NCHAN;
      exp_ack = '0;
      if (!rst && win >= 0 && (q.size() < DEPTH || DROP)) exp_ack[win] = 1'b1;
      checks++;
      assert (ch_ack_o === exp_ack) else begin
         errors++;
         $error("FAIL ack got %b exp %b", ch_ack_o, exp_ack);
      end
      checks++;
      assert (level_o === (AW+1)'(q.size())) else begin
         errors++;
         $error("FAIL level got %0d exp %0d", level_o, q.size());
      end
      checks++;
      assert (rd_valid_o === (q.size() > 0)) else begin
         errors++;
         $error("FAIL rd_valid got %b exp %b", rd_valid_o, q.size() > 0);
      end
      if (q.size() > 0) begin
         checks++;
         assert (rd_data_o === q[0]) else begin
            errors++;
            $error("FAIL rd_data got %h exp %h", rd_data_o, q[0]);
         end
      end
      checks++;
      assert (ovf_o === ovf_m) else begin
         errors++;
         $error("FAIL ovf got %b exp %b", ovf_o, ovf_m);
      end
`ifdef TDC_SCHED_DROP_EN
      checks++;
      assert (drop_cnt_o === 8'(drop_m)) else begin
         errors++;
         $error("FAIL drop_cnt got %0d exp %0d", drop_cnt_o, drop_m);
      end
`endif
      if (rst) begin
         q.delete();
         rr_m = 0;
         ovf_m = 1'b0;
         drop_m = 0;
      end else begin
         do_pop = rd && q.size() > 0;
         do_push = win >= 0 && q.size() < DEPTH;
         stalled = win >= 0 && q.size() == DEPTH;
         if (exp_ack != '0) rr_m = (win + 1) % NCHAN;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back({CW'(win), ts_r[win*TS_W +: TS_W]});
         if (stalled && DROP && drop_m < 255) drop_m++;
         else if (!stalled && DROP && clr) drop_m = 0;
         ovf_m = stalled || (ovf_m && !clr);
      end
      pend = pend & ~exp_ack;
   endtask
   initial begin
      step(1, '0, '0, 0, 0);
      step(1, '0, '0, 0, 0);
      step(0, 4'b0001, 4'hF, 0, 0);
      step(0, '0, 4'hF, 0, 0);
      step(0, '0, 4'hF, 1, 0);
      step(0, '0, 4'hF, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 4'hF, 4'hF, 0, 0);
      step(0, 4'hF, 4'hF, 1, 0);
      step(0, 4'hF, 4'hF, 0, 0);
      step(0, 4'hF, 4'hF, 0, 1);
      step(0, 4'hF, 4'hF, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 4'hF, 4'b1011, 1, 0);
      for (int i = 0; i < 6; i++) step(0, '0, 4'hF, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 4'b0001 << i, 4'hF, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 4'b0010, 4'hF, 1, 0);
      for (int i = 0; i < 6; i++) step(0, '0, 4'hF, 1, 0);
      for (int i = 0; i < 300; i++) step(0, 4'b0010, 4'hF, 0, 0);
      step(0, 4'hF, 4'hF, 0, 1);
      step(1, 4'hF, 4'hF, 0, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 4'hF, 0, 0);
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 99) == 0, NCHAN'($urandom), NCHAN'($urandom | $urandom),
              $urandom_range(0, 99) < ((i / 100) % 2 ? 25 : 75), $urandom_range(0, 19) == 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
